// File: rtl/mem_cache_sequencer_if.sv
// Bus bundle between the MEM-stage sequencer and its pipeline, data cache and SRAM controller.
// master = sequencer view, slave = surrounding pipeline/cache/SRAM view.
interface mem_cache_sequencer_if #(
    parameter int PHYS_W = 19,
    parameter int CNT_W  = 16
);
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              ready;
    logic [31:0]       rdata;

    logic              cache_re;
    logic              cache_we;
    logic              cache_inv;
    logic [PHYS_W-1:0] cache_addr;
    logic [63:0]       cache_wdata;
    logic              cache_hit;
    logic [31:0]       cache_rdata;

    logic              sram_re;
    logic              sram_we;
    logic [PHYS_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [63:0]       sram_rdata;
    logic              sram_ready;

    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport master (
        input  mem_read, mem_write, addr, wdata,
        input  cache_hit, cache_rdata,
        input  sram_rdata, sram_ready,
        output ready, rdata,
        output cache_re, cache_we, cache_inv, cache_addr, cache_wdata,
        output sram_re, sram_we, sram_addr, sram_wdata,
        output hit_cnt, miss_cnt
    );

    modport slave (
        output mem_read, mem_write, addr, wdata,
        output cache_hit, cache_rdata,
        output sram_rdata, sram_ready,
        input  ready, rdata,
        input  cache_re, cache_we, cache_inv, cache_addr, cache_wdata,
        input  sram_re, sram_we, sram_addr, sram_wdata,
        input  hit_cnt, miss_cnt
    );
endinterface

// File: rtl/mem_cache_sequencer.sv
// MEM-stage sequencer: loads hit in the direct-mapped cache or fetch a 64-bit line from SRAM;
// stores are write-through (invalidate line, write word to SRAM). ready=0 freezes the pipeline.
module mem_cache_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          PHYS_W    = 19,
    parameter int          CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_cache_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR      = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end else begin
            return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    function automatic logic [31:0] line_word(input logic [63:0] line, input logic upper);
        if (upper) begin
            return line[63:32];
        end else begin
            return line[31:0];
        end
    endfunction

    state_t            state_r;
    state_t            next_s;
    logic [PHYS_W-1:0] phys_s;
    logic [PHYS_W-1:0] phys_r;
    logic [31:0]       wdata_r;
    logic [CNT_W-1:0]  hit_cnt_r;
    logic [CNT_W-1:0]  miss_cnt_r;

    logic              latch_s;
    logic              store_s;
    logic              hit_evt_s;
    logic              miss_evt_s;

    logic              ready_s;
    logic [31:0]       rdata_s;
    logic              cache_re_s;
    logic              cache_we_s;
    logic              cache_inv_s;
    logic [PHYS_W-1:0] cache_addr_s;
    logic [63:0]       cache_wdata_s;
    logic              sram_re_s;
    logic              sram_we_s;
    logic [PHYS_W-1:0] sram_addr_s;
    logic [31:0]       sram_wdata_s;

    // Data-segment relative address; wraps below the base and keeps only the physical width.
    always_comb begin
        phys_s = PHYS_W'(bus.addr - BASE_ADDR);
    end

    // Next-state and strobe decode; waiting states look only at latched request data.
    always_comb begin
        next_s        = state_r;
        ready_s       = 1'b0;
        rdata_s       = 32'h0;
        cache_re_s    = 1'b0;
        cache_we_s    = 1'b0;
        cache_inv_s   = 1'b0;
        cache_addr_s  = {PHYS_W{1'b0}};
        cache_wdata_s = 64'h0;
        sram_re_s     = 1'b0;
        sram_we_s     = 1'b0;
        sram_addr_s   = {PHYS_W{1'b0}};
        sram_wdata_s  = 32'h0;
        latch_s       = 1'b0;
        store_s       = 1'b0;
        hit_evt_s     = 1'b0;
        miss_evt_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (bus.mem_write) begin
                    cache_inv_s  = 1'b1;
                    cache_addr_s = phys_s;
                    sram_we_s    = 1'b1;
                    sram_addr_s  = phys_s;
                    sram_wdata_s = bus.wdata;
                    latch_s      = 1'b1;
                    store_s      = 1'b1;
                    next_s       = WR;
                end else if (bus.mem_read) begin
                    cache_re_s   = 1'b1;
                    cache_addr_s = phys_s;
                    if (bus.cache_hit) begin
                        ready_s   = 1'b1;
                        rdata_s   = bus.cache_rdata;
                        hit_evt_s = 1'b1;
                    end else begin
                        sram_re_s   = 1'b1;
                        sram_addr_s = {phys_s[PHYS_W-1:3], 3'b000};
                        latch_s     = 1'b1;
                        miss_evt_s  = 1'b1;
                        next_s      = RD_MISS;
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end
            RD_MISS: begin
                sram_re_s   = 1'b1;
                sram_addr_s = {phys_r[PHYS_W-1:3], 3'b000};
                if (bus.sram_ready) begin
                    cache_we_s    = 1'b1;
                    cache_addr_s  = phys_r;
                    cache_wdata_s = bus.sram_rdata;
                    ready_s       = 1'b1;
                    rdata_s       = line_word(bus.sram_rdata, phys_r[2]);
                    next_s        = IDLE;
                end else begin
                    next_s = RD_MISS;
                end
            end
            WR: begin
                sram_we_s    = 1'b1;
                sram_addr_s  = phys_r;
                sram_wdata_s = wdata_r;
                if (bus.sram_ready) begin
                    ready_s = 1'b1;
                    next_s  = IDLE;
                end else begin
                    next_s = WR;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Request latches captured when an access leaves IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phys_r  <= {PHYS_W{1'b0}};
            wdata_r <= 32'h0;
        end else begin
            if (latch_s) begin
                phys_r <= phys_s;
            end
            if (store_s) begin
                wdata_r <= bus.wdata;
            end
        end
    end

    // Saturating load hit/miss statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_r  <= {CNT_W{1'b0}};
            miss_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (hit_evt_s) begin
                hit_cnt_r <= sat_inc(hit_cnt_r);
            end
            if (miss_evt_s) begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end
        end
    end

    assign bus.ready       = ready_s;
    assign bus.rdata       = rdata_s;
    assign bus.cache_re    = cache_re_s;
    assign bus.cache_we    = cache_we_s;
    assign bus.cache_inv   = cache_inv_s;
    assign bus.cache_addr  = cache_addr_s;
    assign bus.cache_wdata = cache_wdata_s;
    assign bus.sram_re     = sram_re_s;
    assign bus.sram_we     = sram_we_s;
    assign bus.sram_addr   = sram_addr_s;
    assign bus.sram_wdata  = sram_wdata_s;
    assign bus.hit_cnt     = hit_cnt_r;
    assign bus.miss_cnt    = miss_cnt_r;

endmodule

// File: tb/tb_mem_cache_sequencer.sv
// Bench for mem_cache_sequencer: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model of the access rules.
module tb_mem_cache_sequencer;

    localparam int PW   = 19;
    localparam int CW   = 6;
    localparam int CMAX = 63;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_cache_sequencer_if #(.PHYS_W(PW), .CNT_W(CW)) bus ();

    mem_cache_sequencer #(
        .BASE_ADDR(32'd1024),
        .PHYS_W   (PW),
        .CNT_W    (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: at most one outstanding access (kind, address, data) plus two counters.
    bit          m_busy, m_store;
    logic [18:0] m_phys;
    logic [31:0] m_wdata;
    int          m_hit, m_miss;
    bit          n_busy, n_store;
    logic [18:0] n_phys;
    logic [31:0] n_wdata;
    int          n_hit, n_miss;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_store = 1'b0; m_phys = 19'd0; m_wdata = 32'd0;
        m_hit = 0; m_miss = 0;
    endtask

    // Compare all meaningful outputs mid-cycle and work out the model's next step.
    task automatic sample();
        logic [31:0] d;
        logic [18:0] p;
        bit          e_ready, e_cre, e_cwe, e_inv, e_sre, e_swe, e_rv;
        logic [18:0] e_caddr, e_saddr;
        logic [31:0] e_rdata, e_swdata;
        #3;
        d = bus.addr - 32'd1024;
        p = d[18:0];
        e_ready = 1'b0; e_cre = 1'b0; e_cwe = 1'b0; e_inv = 1'b0;
        e_sre = 1'b0; e_swe = 1'b0; e_rv = 1'b0;
        e_caddr = 19'd0; e_saddr = 19'd0; e_rdata = 32'd0; e_swdata = 32'd0;
        n_busy = m_busy; n_store = m_store; n_phys = m_phys; n_wdata = m_wdata;
        n_hit = m_hit; n_miss = m_miss;
        if (!m_busy) begin
            if (bus.mem_write) begin
                e_inv = 1'b1; e_caddr = p; e_swe = 1'b1; e_saddr = p; e_swdata = bus.wdata;
                n_busy = 1'b1; n_store = 1'b1; n_phys = p; n_wdata = bus.wdata;
            end else if (bus.mem_read) begin
                e_cre = 1'b1; e_caddr = p;
                if (bus.cache_hit) begin
                    e_ready = 1'b1; e_rv = 1'b1; e_rdata = bus.cache_rdata;
                    n_hit = (m_hit < CMAX) ? m_hit + 1 : CMAX;
                end else begin
                    e_sre = 1'b1; e_saddr = p & ~19'd7;
                    n_busy = 1'b1; n_store = 1'b0; n_phys = p;
                    n_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
                end
            end else begin
                e_ready = 1'b1;
            end
        end else if (!m_store) begin
            e_sre = 1'b1; e_saddr = m_phys & ~19'd7;
            if (bus.sram_ready) begin
                e_cwe = 1'b1; e_caddr = m_phys; e_ready = 1'b1; e_rv = 1'b1;
                e_rdata = m_phys[2] ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
                n_busy = 1'b0;
            end
        end else begin
            e_swe = 1'b1; e_saddr = m_phys; e_swdata = m_wdata;
            e_ready = bus.sram_ready;
            if (bus.sram_ready) n_busy = 1'b0;
        end

        chk("ready", bus.ready, e_ready);
        chk("cache_re", bus.cache_re, e_cre);
        chk("cache_we", bus.cache_we, e_cwe);
        chk("cache_inv", bus.cache_inv, e_inv);
        chk("sram_re", bus.sram_re, e_sre);
        chk("sram_we", bus.sram_we, e_swe);
        chk("hit_cnt", bus.hit_cnt, m_hit);
        chk("miss_cnt", bus.miss_cnt, m_miss);
        if (e_cre || e_cwe || e_inv) chk("cache_addr", bus.cache_addr, e_caddr);
        if (e_cwe) chk("cache_wdata", bus.cache_wdata, bus.sram_rdata);
        if (e_sre || e_swe) chk("sram_addr", bus.sram_addr, e_saddr);
        if (e_swe) chk("sram_wdata", bus.sram_wdata, e_swdata);
        if (e_rv) chk("rdata", bus.rdata, e_rdata);
    endtask

    task automatic advance();
        @(posedge clk);
        m_busy = n_busy; m_store = n_store; m_phys = n_phys; m_wdata = n_wdata;
        m_hit = n_hit; m_miss = n_miss;
        #1;
    endtask

    task automatic quiet();
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.sram_ready = 1'b0; bus.cache_hit = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0;
        bus.addr = 32'd0; bus.wdata = 32'd0; bus.cache_rdata = 32'd0; bus.sram_rdata = 64'd0;
        quiet();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: idle after reset
        repeat (3) begin
            sample();
            chk("idle_ready", bus.ready, 1'b1);
            chk("idle_strobes", {bus.cache_re, bus.cache_we, bus.cache_inv, bus.sram_re, bus.sram_we}, 5'b00000);
            chk("idle_cnts", {bus.hit_cnt, bus.miss_cnt}, 12'd0);
            advance();
        end

        // 2: load miss at 1024, completion on the 4th cycle
        bus.addr = 32'd1024; bus.mem_read = 1'b1; bus.cache_hit = 1'b0;
        sample();
        chk("miss_ready0", bus.ready, 1'b0);
        chk("miss_sram_re", bus.sram_re, 1'b1);
        chk("miss_sram_addr", bus.sram_addr, 19'd0);
        advance();
        bus.mem_read = 1'b0; bus.addr = 32'd5000;
        repeat (2) begin
            sample();
            chk("miss_wait_ready", bus.ready, 1'b0);
            chk("miss_wait_addr", bus.sram_addr, 19'd0);
            advance();
        end
        bus.sram_ready = 1'b1; bus.sram_rdata = 64'hAAAA_BBBB_1111_2222;
        sample();
        chk("fill_ready", bus.ready, 1'b1);
        chk("fill_rdata", bus.rdata, 32'h1111_2222);
        chk("fill_we", bus.cache_we, 1'b1);
        chk("fill_wdata", bus.cache_wdata, 64'hAAAA_BBBB_1111_2222);
        advance();
        bus.sram_ready = 1'b0;
        sample();
        chk("miss_cnt_1", bus.miss_cnt, 6'd1);
        advance();

        // 3: hit at 1028
        bus.addr = 32'd1028; bus.mem_read = 1'b1; bus.cache_hit = 1'b1; bus.cache_rdata = 32'hAAAA_BBBB;
        sample();
        chk("hit_ready", bus.ready, 1'b1);
        chk("hit_rdata", bus.rdata, 32'hAAAA_BBBB);
        chk("hit_no_sram", bus.sram_re, 1'b0);
        advance();
        quiet();
        sample();
        chk("hit_cnt_1", bus.hit_cnt, 6'd1);
        advance();

        // 4: store at 1032, inputs changed while waiting
        bus.addr = 32'd1032; bus.wdata = 32'hDEAD_BEEF; bus.mem_write = 1'b1;
        sample();
        chk("st_inv", bus.cache_inv, 1'b1);
        chk("st_caddr", bus.cache_addr, 19'd8);
        chk("st_we", bus.sram_we, 1'b1);
        chk("st_saddr", bus.sram_addr, 19'd8);
        advance();
        bus.mem_write = 1'b0; bus.addr = 32'd2000; bus.wdata = 32'h1234_5678;
        repeat (2) begin
            sample();
            chk("st_hold_addr", bus.sram_addr, 19'd8);
            chk("st_hold_data", bus.sram_wdata, 32'hDEAD_BEEF);
            chk("st_hold_ready", bus.ready, 1'b0);
            advance();
        end
        bus.sram_ready = 1'b1;
        sample();
        chk("st_done", bus.ready, 1'b1);
        advance();
        quiet();

        // 5: simultaneous read and write takes the store path
        bus.addr = 32'd1100; bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.cache_hit = 1'b1;
        sample();
        chk("both_inv", bus.cache_inv, 1'b1);
        chk("both_no_re", bus.cache_re, 1'b0);
        advance();
        quiet();
        bus.sram_ready = 1'b1;
        sample();
        advance();
        bus.sram_ready = 1'b0;
        sample();
        chk("both_cnts", {bus.hit_cnt, bus.miss_cnt}, {6'd1, 6'd1});
        advance();

        // 6: asynchronous reset in the middle of a line fetch
        bus.addr = 32'd1040; bus.mem_read = 1'b1; bus.cache_hit = 1'b0;
        sample();
        advance();
        bus.mem_read = 1'b0;
        sample();
        rst = 1'b0; bus.sram_ready = 1'b1;
        #1;
        chk("rst_sram_re", bus.sram_re, 1'b0);
        chk("rst_no_fill", bus.cache_we, 1'b0);
        chk("rst_cnts", {bus.hit_cnt, bus.miss_cnt}, 12'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_held_we", bus.cache_we, 1'b0);
        bus.sram_ready = 1'b0; rst = 1'b1;
        sample();
        chk("post_rst_ready", bus.ready, 1'b1);
        advance();

        // Randomized traffic, including addresses below the base and stray sram_ready pulses
        for (int i = 0; i < 3000; i++) begin
            int op;
            op = $urandom_range(0, 9);
            bus.mem_read  = (op <= 3) || (op == 6);
            bus.mem_write = (op == 4) || (op == 5) || (op == 6);
            bus.addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'd1024 + $urandom_range(0, 4095);
            bus.wdata = $urandom;
            bus.cache_hit = $urandom_range(0, 1) == 1;
            bus.cache_rdata = $urandom;
            bus.sram_rdata = {$urandom, $urandom};
            bus.sram_ready = $urandom_range(0, 3) == 0;
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
